// File: rtl/vc_scheduler_ctrl.sv
// Virtual-channel scheduler: owns FIFO init and thresholds, arbitrates VC0 > VC1 reads
// and steers the read words into destination FIFOs D0/D1 through a two-stage pipeline.
module vc_scheduler_ctrl #(
    parameter int DATA_WIDTH = 6,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [3:0]            umbral_vc0_in,
    input  logic [3:0]            umbral_vc1_in,
    input  logic [3:0]            umbral_d_in,
    input  logic                  empty_vc0,
    input  logic                  empty_vc1,
    input  logic                  almost_full_d0,
    input  logic                  almost_full_d1,
    input  logic [DATA_WIDTH-1:0] data_vc0,
    input  logic [DATA_WIDTH-1:0] data_vc1,
    output logic                  init_fifo,
    output logic [3:0]            umbral_vc0,
    output logic [3:0]            umbral_vc1,
    output logic [3:0]            umbral_d,
    output logic                  pop_vc0,
    output logic                  pop_vc1,
    output logic                  push_d0,
    output logic                  push_d1,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [CNT_WIDTH-1:0]  cnt_d0,
    output logic [CNT_WIDTH-1:0]  cnt_d1,
    output logic [1:0]            state,
    output logic                  idle
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [3:0]              r_umbral_vc0;
    logic [3:0]              r_umbral_vc1;
    logic [3:0]              r_umbral_d;
    logic                    r_s1_valid;
    logic                    r_s1_src;
    logic                    r_push_d0;
    logic                    r_push_d1;
    logic [DATA_WIDTH-1:0]   r_data_out;
    logic [CNT_WIDTH-1:0]    r_cnt_d0;
    logic [CNT_WIDTH-1:0]    r_cnt_d1;
    logic                    w_pop_ok;
    logic                    w_pop_vc0;
    logic                    w_pop_vc1;
    logic                    w_pipe_empty;
    logic [DATA_WIDTH-1:0]   w_s1_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    assign w_pipe_empty = !r_s1_valid && !r_push_d0 && !r_push_d1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RESET:  w_next = ST_INIT;
            ST_INIT:   if (!init) w_next = ST_IDLE;
            ST_IDLE: begin
                if (init)                         w_next = ST_INIT;
                else if (!empty_vc0 || !empty_vc1) w_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)                                        w_next = ST_INIT;
                else if (empty_vc0 && empty_vc1 && w_pipe_empty) w_next = ST_IDLE;
            end
            default:   w_next = ST_RESET;
        endcase
    end

    // Strict priority: VC1 is only read in a cycle where VC0 has nothing to offer.
    assign w_pop_ok  = (r_state == ST_ACTIVE) && !init && !almost_full_d0 && !almost_full_d1;
    assign w_pop_vc0 = w_pop_ok && !empty_vc0;
    assign w_pop_vc1 = w_pop_ok && !w_pop_vc0 && !empty_vc1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_umbral_vc0 <= '0;
            r_umbral_vc1 <= '0;
            r_umbral_d   <= '0;
        end else if (r_state == ST_INIT) begin
            r_umbral_vc0 <= umbral_vc0_in;
            r_umbral_vc1 <= umbral_vc1_in;
            r_umbral_d   <= umbral_d_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_src   <= 1'b0;
        end else if (init) begin
            r_s1_valid <= 1'b0;
            r_s1_src   <= 1'b0;
        end else begin
            r_s1_valid <= w_pop_vc0 || w_pop_vc1;
            r_s1_src   <= w_pop_vc1;
        end
    end

    // Source FIFOs present the popped word one cycle after the pop; stage 2 captures it here.
    assign w_s1_data = r_s1_src ? data_vc1 : data_vc0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_push_d0  <= 1'b0;
            r_push_d1  <= 1'b0;
            r_data_out <= '0;
        end else if (init || !r_s1_valid) begin
            r_push_d0  <= 1'b0;
            r_push_d1  <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_push_d0  <= !w_s1_data[DATA_WIDTH-1];
            r_push_d1  <= w_s1_data[DATA_WIDTH-1];
            r_data_out <= w_s1_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt_d0 <= '0;
            r_cnt_d1 <= '0;
        end else begin
            if (r_push_d0) r_cnt_d0 <= r_cnt_d0 + 1'b1;
            if (r_push_d1) r_cnt_d1 <= r_cnt_d1 + 1'b1;
        end
    end

    assign init_fifo  = (r_state == ST_IDLE) || (r_state == ST_ACTIVE);
    assign umbral_vc0 = r_umbral_vc0;
    assign umbral_vc1 = r_umbral_vc1;
    assign umbral_d   = r_umbral_d;
    assign pop_vc0    = w_pop_vc0;
    assign pop_vc1    = w_pop_vc1;
    assign push_d0    = r_push_d0;
    assign push_d1    = r_push_d1;
    assign data_out   = r_data_out;
    assign cnt_d0     = r_cnt_d0;
    assign cnt_d1     = r_cnt_d1;
    assign state      = r_state;
    assign idle       = (r_state == ST_IDLE);

endmodule

// File: tb/tb_vc_scheduler_ctrl.sv
// Directed bench for vc_scheduler_ctrl with behavioural source FIFOs and a push scoreboard.
module tb_vc_scheduler_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [3:0] umbral_vc0_in, umbral_vc1_in, umbral_d_in;
    logic       empty_vc0, empty_vc1, almost_full_d0, almost_full_d1;
    logic [5:0] data_vc0, data_vc1;
    logic       init_fifo;
    logic [3:0] umbral_vc0, umbral_vc1, umbral_d;
    logic       pop_vc0, pop_vc1, push_d0, push_d1;
    logic [5:0] data_out;
    logic [7:0] cnt_d0, cnt_d1;
    logic [1:0] state;
    logic       idle;

    vc_scheduler_ctrl #(.DATA_WIDTH(6), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .init(init),
        .umbral_vc0_in(umbral_vc0_in), .umbral_vc1_in(umbral_vc1_in), .umbral_d_in(umbral_d_in),
        .empty_vc0(empty_vc0), .empty_vc1(empty_vc1),
        .almost_full_d0(almost_full_d0), .almost_full_d1(almost_full_d1),
        .data_vc0(data_vc0), .data_vc1(data_vc1),
        .init_fifo(init_fifo), .umbral_vc0(umbral_vc0), .umbral_vc1(umbral_vc1), .umbral_d(umbral_d),
        .pop_vc0(pop_vc0), .pop_vc1(pop_vc1), .push_d0(push_d0), .push_d1(push_d1),
        .data_out(data_out), .cnt_d0(cnt_d0), .cnt_d1(cnt_d1), .state(state), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] d;
        int         due;
    } sb_t;

    sb_t        sb[$];
    logic [5:0] q0[$];
    logic [5:0] q1[$];
    int total = 0, bad = 0, cyc = 0;
    int m_cnt0 = 0, m_cnt1 = 0;
    int n_pop0 = 0, n_pop1 = 0, last_p0 = -1, first_p1 = -1, af_pushes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load0(input logic [5:0] w);
        q0.push_back(w);
        empty_vc0 = 1'b0;
    endtask

    task automatic load1(input logic [5:0] w);
        q1.push_back(w);
        empty_vc1 = 1'b0;
    endtask

    // One clock: check pushes/counters at the falling edge, then model the source FIFOs.
    task automatic tick();
        sb_t  e;
        logic p0, p1;
        bit   exp0, exp1;
        @(negedge clk);
        cyc++;
        exp0 = 1'b0;
        exp1 = 1'b0;
        chk("cnt_d0", 32'(cnt_d0), 32'(m_cnt0));
        chk("cnt_d1", 32'(cnt_d1), 32'(m_cnt1));
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            exp0 = !e.d[5];
            exp1 = e.d[5];
            chk("push_d0", 32'(push_d0), 32'(exp0));
            chk("push_d1", 32'(push_d1), 32'(exp1));
            chk("data_out", 32'(data_out), 32'(e.d));
        end else begin
            chk("no_push", 32'({push_d0, push_d1}), 32'd0);
        end
        if (exp0) m_cnt0 = (m_cnt0 + 1) % 256;
        if (exp1) m_cnt1 = (m_cnt1 + 1) % 256;
        chk("pop_excl", 32'(pop_vc0 & pop_vc1), 32'd0);
        if (init || almost_full_d0 || almost_full_d1)
            chk("pop_hold", 32'({pop_vc0, pop_vc1}), 32'd0);
        if (pop_vc1) chk("pop_prio", 32'(empty_vc0), 32'd1);
        if (almost_full_d0 || almost_full_d1) af_pushes += int'(push_d0 | push_d1);
        p0 = pop_vc0;
        p1 = pop_vc1;
        if (p0 && q0.size() > 0) begin
            sb.push_back('{d: q0[0], due: cyc + 2});
            n_pop0++;
            last_p0 = cyc;
        end
        if (p1 && q1.size() > 0) begin
            sb.push_back('{d: q1[0], due: cyc + 2});
            n_pop1++;
            if (first_p1 < 0) first_p1 = cyc;
        end
        if (init) sb.delete();
        @(posedge clk);
        #1;
        data_vc0 = (p0 && q0.size() > 0) ? q0.pop_front() : 6'h00;
        data_vc1 = (p1 && q1.size() > 0) ? q1.pop_front() : 6'h00;
        empty_vc0 = (q0.size() == 0);
        empty_vc1 = (q1.size() == 0);
        #1;
    endtask

    task automatic run_idle(input int maxc);
        int n = 0;
        tick();
        while (state !== 2'd2 && n < maxc) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(state), 32'd2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int n;
        reset = 1'b0; init = 1'b1;
        umbral_vc0_in = 4'd3; umbral_vc1_in = 4'd4; umbral_d_in = 4'd2;
        empty_vc0 = 1'b1; empty_vc1 = 1'b1;
        almost_full_d0 = 1'b0; almost_full_d1 = 1'b0;
        data_vc0 = '0; data_vc1 = '0;
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_init_fifo", 32'(init_fifo), 32'd0);
        chk("rst_umbral_vc0", 32'(umbral_vc0), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_cnt_d0", 32'(cnt_d0), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rel_state", 32'(state), 32'd0);
        tick();
        chk("init_state", 32'(state), 32'd1);
        chk("init_fifo_low", 32'(init_fifo), 32'd0);
        tick();
        init = 1'b0;
        tick();
        chk("idle_state", 32'(state), 32'd2);
        chk("idle_flag", 32'(idle), 32'd1);
        chk("umbral_vc0", 32'(umbral_vc0), 32'd3);
        chk("umbral_vc1", 32'(umbral_vc1), 32'd4);
        chk("umbral_d", 32'(umbral_d), 32'd2);
        chk("idle_init_fifo", 32'(init_fifo), 32'd1);
        chk("idle_pops", 32'({pop_vc0, pop_vc1, push_d0, push_d1}), 32'd0);

        // VC0 only, mixed destinations
        load0(6'h05); load0(6'h21); load0(6'h0A);
        n_pop0 = 0;
        run_idle(20);
        chk("t2_pops", 32'(n_pop0), 32'd3);
        chk("t2_cnt_d0", 32'(cnt_d0), 32'd2);
        chk("t2_cnt_d1", 32'(cnt_d1), 32'd1);

        // Both VCs loaded: VC0 drains first, VC1 follows without a gap
        load0(6'h01); load0(6'h02); load1(6'h23); load1(6'h04);
        n_pop0 = 0; n_pop1 = 0; last_p0 = -1; first_p1 = -1;
        run_idle(20);
        chk("t3_pop0", 32'(n_pop0), 32'd2);
        chk("t3_pop1", 32'(n_pop1), 32'd2);
        chk("t3_handover", 32'(first_p1), 32'(last_p0 + 1));

        // Destination almost full mid-stream
        for (int unsigned i = 1; i <= 6; i++) load0(6'(i));
        repeat (3) tick();
        almost_full_d1 = 1'b1;
        #1;
        chk("t4_pop_stop", 32'(pop_vc0), 32'd0);
        n_pop0 = 0; af_pushes = 0;
        repeat (4) tick();
        chk("t4_af_pushes", 32'(af_pushes), 32'd2);
        chk("t4_af_pops", 32'(n_pop0), 32'd0);
        almost_full_d1 = 1'b0;
        #1;
        chk("t4_pop_resume", 32'(pop_vc0), 32'd1);
        run_idle(30);

        // init while words are in flight
        load0(6'h11); load0(6'h12); load0(6'h13); load0(6'h14);
        repeat (3) tick();
        init = 1'b1;
        #1;
        chk("t5_pop_blocked", 32'(pop_vc0), 32'd0);
        tick();
        chk("t5_state", 32'(state), 32'd1);
        chk("t5_init_fifo", 32'(init_fifo), 32'd0);
        chk("t5_no_push", 32'({push_d0, push_d1}), 32'd0);
        s0 = m_cnt0;
        repeat (2) tick();
        chk("t5_cnt_hold", 32'(cnt_d0), 32'(s0));
        q0.delete(); q1.delete();
        empty_vc0 = 1'b1; empty_vc1 = 1'b1;
        init = 1'b0;
        tick();
        chk("t5_idle", 32'(state), 32'd2);

        // Counter wrap on D0
        n = 255 - m_cnt0;
        for (int unsigned i = 0; i < n; i++) load0(6'h01);
        run_idle(400);
        chk("t6_cnt_255", 32'(cnt_d0), 32'd255);
        load0(6'h02);
        run_idle(20);
        chk("t6_cnt_wrap", 32'(cnt_d0), 32'd0);

        // Asynchronous reset mid-transfer
        load0(6'h03); load0(6'h04); load0(6'h05);
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("t7_state", 32'(state), 32'd0);
        chk("t7_push", 32'({push_d0, push_d1}), 32'd0);
        chk("t7_data_out", 32'(data_out), 32'd0);
        chk("t7_cnt_d0", 32'(cnt_d0), 32'd0);
        chk("t7_cnt_d1", 32'(cnt_d1), 32'd0);
        chk("t7_umbral_d", 32'(umbral_d), 32'd0);
        chk("t7_init_fifo", 32'(init_fifo), 32'd0);
        chk("t7_pop", 32'({pop_vc0, pop_vc1}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vc_scheduler_ctrl.md
Name: vc_scheduler_ctrl

Overview:
- Sequences two virtual-channel FIFOs (VC0, VC1) and steers their data into two destination FIFOs (D0, D1).
- Owns FIFO initialisation, stores the almost-empty/almost-full thresholds, and arbitrates reads with strict priority VC0 > VC1.
- Holds reads off while either destination is almost full.
- Sits between the VC FIFO bank and the per-destination FIFOs in the transaction-layer datapath.

Parameters:
- DATA_WIDTH, 6, width of a FIFO word; bit DATA_WIDTH-1 selects the destination (0 -> D0, 1 -> D1).
- CNT_WIDTH, 8, width of each per-destination transfer counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- init  in  1  configuration request; high forces the INIT state.
- umbral_vc0_in  in  4  VC0 threshold, latched in INIT.
- umbral_vc1_in  in  4  VC1 threshold, latched in INIT.
- umbral_d_in  in  4  D0/D1 threshold, latched in INIT.
- empty_vc0, empty_vc1  in  1  source FIFO empty flags.
- almost_full_d0, almost_full_d1  in  1  destination almost-full flags.
- data_vc0, data_vc1  in  DATA_WIDTH  registered read data from the source FIFOs; 0 when not read.
- init_fifo  out  1  FIFO init strobe; 0 clears the FIFOs.
- umbral_vc0, umbral_vc1, umbral_d  out  4  latched thresholds to the FIFOs.
- pop_vc0, pop_vc1  out  1  source read enables (combinational).
- push_d0, push_d1  out  1  destination write enables (registered).
- data_out  out  DATA_WIDTH  destination write data (registered).
- cnt_d0, cnt_d1  out  CNT_WIDTH  words pushed to each destination.
- state  out  2  current state: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
- idle  out  1  high when state==IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RESET; all registered outputs 0; umbral_* = 0; init_fifo=0; pipeline valid bits cleared.
- State transitions:
  - RESET -> INIT on the first clock edge with reset=1.
  - INIT:
    - init_fifo=0.
    - umbral_* registers load from umbral_*_in on every edge.
    - Go to IDLE on the edge where init==0.
  - IDLE:
    - init_fifo=1.
    - Go to ACTIVE when empty_vc0==0 or empty_vc1==0.
  - ACTIVE:
    - init_fifo=1.
    - Go to IDLE when both sources are empty and both pipeline stages are invalid.
  - From IDLE or ACTIVE, init==1 -> INIT on the next edge. Both pipeline stages are flushed and no further push is issued.
- Pop arbitration (combinational):
  - Pops are allowed only when state==ACTIVE, init==0, almost_full_d0==0 and almost_full_d1==0.
  - When allowed: pop_vc0 = !empty_vc0; pop_vc1 = !pop_vc0 && !empty_vc1.
  - At most one pop per cycle.
- Pipeline:
  - Pop at edge N.
  - Stage1 records valid and source at N.
  - Source FIFO presents data during N+1.
  - Stage2 registers data_out, and sets push_d0 when data[DATA_WIDTH-1]==0, push_d1 otherwise, at edge N+1.
  - The push is therefore visible in cycle N+2: pop-to-push latency 2 cycles, throughput 1 word/cycle.
  - When there is no valid stage1 word: push_d0=push_d1=0 and data_out=0.
- Counters:
  - cnt_dX increments by 1 on each cycle push_dX is high; wraps 2^CNT_WIDTH-1 -> 0.
  - Counters clear only on reset; they are not cleared by INIT.
- Almost-full margin: up to 2 words are in flight after the flag rises. umbral_d must be >=2; the block does not check this.
- Reset mid-transfer: in-flight words are dropped and outputs return to their reset values immediately.
- Simultaneous events: init==1 has priority over all pops; state moves to INIT even if sources are non-empty.

Test Plan:
- Reset=0 for 2 cycles, then release with init=1 and umbral_*_in=3,4,2 -> state RESET then INIT. Then init=0 -> IDLE, umbral_*=3/4/2, init_fifo=1, all push/pop 0.
- VC0 holds 3 words 0x05,0x21,0x0A, VC1 empty, destinations not full -> pop_vc0 high 3 cycles. push_d0 at +2 cycles with 0x05, push_d1 with 0x21, push_d0 with 0x0A. Final cnt_d0=2, cnt_d1=1; return to IDLE.
- Both VCs non-empty -> pop_vc1 stays 0 until empty_vc0=1, then pop_vc1 asserts the same cycle.
- almost_full_d1=1 mid-stream -> pops stop the same cycle. At most 2 more pushes complete. Pops resume the cycle the flag drops.
- init=1 while ACTIVE with words in flight -> next cycle state=INIT, init_fifo=0. No push after the edge; counters hold.
- cnt_d0 preloaded to 255 via 255 pushes, then one more push -> cnt_d0=0.
